// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature decoder: A/B phase codes, FSM states, direction.
// No timing of its own; holds constants and one pure function.
// No flow control; nothing here is clocked.
package quad_pkg;

    // Phase codes, written as {A,B}
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Successor of a phase in the forward rotation 00->10->11->01->00.
    // A step backwards is recognised as next_up(cur) == prev.
    function automatic logic [1:0] next_up(input logic [1:0] ph);
        logic [1:0] nx;
        case (ph)
            PH_00:   nx = PH_10;
            PH_10:   nx = PH_11;
            PH_11:   nx = PH_01;
            default: nx = PH_00;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser for an asynchronous input pin.
// Latency: STAGES clk edges from pin to q_o.
// No backpressure; samples every cycle.
// Ports: clk, rst (sync, active-high, clears chain to 0), d_i async in, q_o synchronised out.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: synchronised A/B edges drive an N-bit wrap-around up/down count.
// Latency: pin edge sampled at clk edge k shows on Q/step after edge k+SYNC_STAGES.
// No backpressure; en gates counting only, phase tracking never stalls.
// Ports: clk, rst (sync active-high), en, clr, a_in/b_in async encoder phases;
//        Q count, dir last legal direction, step 1-cycle pulse, err sticky illegal-edge flag,
//        tc_up (Q all ones), tc_down (Q zero).
module quad_decoder
    import quad_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         a_in,
    input  logic         b_in,
    output logic [N-1:0] Q,
    output logic         dir,
    output logic         step,
    output logic         err,
    output logic         tc_up,
    output logic         tc_down
);

    localparam int             CW         = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0]  PRIME_LAST = CW'(SYNC_STAGES);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [N-1:0]   ONE        = N'(1);

    logic a_s;
    logic b_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk (clk),
        .rst (rst),
        .d_i (a_in),
        .q_o (a_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk (clk),
        .rst (rst),
        .d_i (b_in),
        .q_o (b_s)
    );

    state_t        state_q;
    logic [CW-1:0] prime_cnt_q;
    logic [1:0]    prev_q;
    logic [N-1:0]  q_q;
    logic          dir_q;
    logic          step_q;
    logic          err_q;

    // Transition decode against the previously seen phase
    logic [1:0] cur_d;
    logic       up_d;
    logic       dn_d;
    logic       bad_d;

    always_comb begin
        cur_d = {a_s, b_s};
        up_d  = (next_up(prev_q) == cur_d);
        dn_d  = (next_up(cur_d) == prev_q);
        bad_d = ((cur_d ^ prev_q) == 2'b11);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PRIME;
            prime_cnt_q <= '0;
            prev_q      <= PH_00;
            q_q         <= '0;
            dir_q       <= DIR_DOWN;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                // Wait until the synchroniser chains hold real pin values, then
                // adopt them as the reference so a power-up mismatch is not an edge.
                ST_PRIME: begin
                    if (prime_cnt_q == PRIME_LAST) begin
                        prev_q  <= cur_d;
                        state_q <= ST_RUN;
                    end else begin
                        prime_cnt_q <= prime_cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    // prev always follows the pins, so disabled periods and illegal
                    // jumps never leave a backlog of counts.
                    prev_q <= cur_d;
                    if (bad_d) begin
                        err_q <= 1'b1;
                    end
                    if (en && (up_d || dn_d)) begin
                        q_q    <= up_d ? (q_q + ONE) : (q_q - ONE);
                        dir_q  <= up_d ? DIR_UP : DIR_DOWN;
                        step_q <= 1'b1;
                    end
                end
                default: state_q <= ST_PRIME;
            endcase
            // Clear wins over a step landing in the same cycle
            if (clr) begin
                q_q    <= '0;
                err_q  <= 1'b0;
                step_q <= 1'b0;
            end
        end
    end

    assign Q       = q_q;
    assign dir     = dir_q;
    assign step    = step_q;
    assign err     = err_q;
    assign tc_up   = &q_q;
    assign tc_down = (q_q == '0);

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed A/B edge vectors with a step scoreboard.
// Expected {Q,dir} pushed at stimulus time; a negedge monitor pops on every step pulse.
// Held-state conditions are checked directly against hand-computed constants.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic       a_in;
    logic       b_in;
    logic [7:0] Q;
    logic       dir;
    logic       step;
    logic       err;
    logic       tc_up;
    logic       tc_down;

    int tests = 0;
    int fails = 0;
    int step_seen = 0;

    logic [8:0] sb[$];      // {expected Q, expected dir}
    logic [7:0] mq;         // model count
    logic       mdir;

    always #5 clk = ~clk;

    quad_decoder #(.N(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .a_in    (a_in),
        .b_in    (b_in),
        .Q       (Q),
        .dir     (dir),
        .step    (step),
        .err     (err),
        .tc_up   (tc_up),
        .tc_down (tc_down)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every step pulse must match the oldest expected step
    always @(negedge clk) begin
        if (!rst && step) begin
            step_seen++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_step: got step with Q=%0d, expected no step", Q);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                check("step_Q", int'(Q), int'(e[8:1]));
                check("step_dir", int'(dir), int'(e[0]));
            end
        end
    end

    // Drive one phase change and hold it 4 clocks. kind: 1 up, -1 down, 0 not counted.
    task automatic edge_to(input logic [1:0] nph, input int kind);
        @(posedge clk); #1;
        if (kind == 1) begin
            mq = mq + 8'd1; mdir = 1'b1; sb.push_back({mq, mdir});
        end else if (kind == -1) begin
            mq = mq - 8'd1; mdir = 1'b0; sb.push_back({mq, mdir});
        end
        a_in = nph[1];
        b_in = nph[0];
        repeat (4) @(posedge clk);
        #1;
    endtask

    int s0;

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; a_in = 1'b1; b_in = 1'b1;
        mq = 8'd0; mdir = 1'b0;

        // Reset with pins at 11
        repeat (3) @(posedge clk);
        #1;
        check("rst_Q", int'(Q), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_step", int'(step), 0);
        check("rst_err", int'(err), 0);
        check("rst_tc_down", int'(tc_down), 1);
        check("rst_tc_up", int'(tc_up), 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("prime_Q", int'(Q), 0);
        check("prime_err", int'(err), 0);
        check("prime_no_step", step_seen, 0);

        // Four full up rotations starting from 11
        for (int i = 0; i < 4; i++) begin
            edge_to(2'b01, 1);
            edge_to(2'b00, 1);
            edge_to(2'b10, 1);
            edge_to(2'b11, 1);
        end
        check("up16_Q", int'(Q), 16);
        check("up16_dir", int'(dir), 1);
        check("up16_steps", step_seen, 16);

        // Five down edges from 11
        edge_to(2'b10, -1);
        edge_to(2'b00, -1);
        edge_to(2'b01, -1);
        edge_to(2'b11, -1);
        edge_to(2'b10, -1);
        check("dn5_Q", int'(Q), 11);
        check("dn5_dir", int'(dir), 0);

        // Illegal 00 -> 11, then a legal up edge, then clr
        edge_to(2'b00, -1);
        s0 = step_seen;
        edge_to(2'b11, 0);
        check("ill_err", int'(err), 1);
        check("ill_Q", int'(Q), 10);
        check("ill_no_step", step_seen, s0);
        edge_to(2'b01, 1);
        check("ill_recover_Q", int'(Q), 11);
        check("ill_err_sticky", int'(err), 1);
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        mq = 8'd0;
        check("clr_Q", int'(Q), 0);
        check("clr_err", int'(err), 0);

        // Wrap both ways, phase is 01
        edge_to(2'b11, -1);
        check("wrap_dn_Q", int'(Q), 255);
        check("wrap_dn_tc_up", int'(tc_up), 1);
        check("wrap_dn_tc_down", int'(tc_down), 0);
        edge_to(2'b01, 1);
        check("wrap_up_Q", int'(Q), 0);
        check("wrap_up_tc_down", int'(tc_down), 1);
        check("wrap_up_tc_up", int'(tc_up), 0);
        edge_to(2'b11, -1);
        check("wrap_dn2_Q", int'(Q), 255);
        check("wrap_dn2_tc_up", int'(tc_up), 1);

        // Disabled counting: six up edges ignored, no catch-up afterwards
        en = 1'b0;
        s0 = step_seen;
        edge_to(2'b01, 0);
        edge_to(2'b00, 0);
        edge_to(2'b10, 0);
        edge_to(2'b11, 0);
        edge_to(2'b01, 0);
        edge_to(2'b00, 0);
        check("en0_Q", int'(Q), 255);
        check("en0_steps", step_seen, s0);
        check("en0_err", int'(err), 0);
        en = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("en1_idle_Q", int'(Q), 255);
        check("en1_idle_steps", step_seen, s0);
        edge_to(2'b10, 1);
        check("en1_next_Q", int'(Q), 0);

        // clr coinciding with a counted step (phase is 10)
        edge_to(2'b01, 0);
        check("ill2_err", int'(err), 1);
        edge_to(2'b00, 1);
        check("pre_clr_Q", int'(Q), 1);
        s0 = step_seen;
        @(posedge clk); #1;
        a_in = 1'b1; b_in = 1'b0;       // 00 -> 10, sampled next edge (k)
        @(posedge clk);                 // k
        @(posedge clk); #1; clr = 1'b1; // held across edge k+2, where the step lands
        @(posedge clk); #1; clr = 1'b0;
        check("clrstep_Q", int'(Q), 0);
        check("clrstep_step", int'(step), 0);
        check("clrstep_err", int'(err), 0);
        mq = 8'd0;
        repeat (4) @(posedge clk);
        #1;
        check("clrstep_no_pulse", step_seen, s0);
        check("clrstep_Q_hold", int'(Q), 0);

        // Reset mid-rotation, re-prime, resume
        edge_to(2'b11, 1);
        check("pre_rst_Q", int'(Q), 1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_Q", int'(Q), 0);
        check("mrst_dir", int'(dir), 0);
        check("mrst_step", int'(step), 0);
        check("mrst_err", int'(err), 0);
        rst = 1'b0;
        mq = 8'd0; mdir = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reprime_Q", int'(Q), 0);
        check("reprime_err", int'(err), 0);
        edge_to(2'b01, 1);
        edge_to(2'b00, 1);
        check("resume_Q", int'(Q), 2);
        check("resume_dir", int'(dir), 1);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
Quadrature (A/B) decoder that turns a two-phase incremental encoder stream into an N-bit up/down position count. It sits at the input end of the counter interface and produces the count, direction and terminal-count flags that software and downstream logic already consume from the counter. Decoding is x4, so every legal A/B edge is one count. Asynchronous encoder pins are synchronised internally.

Parameters:
N, 8, position counter width
SYNC_STAGES, 2, flip-flop stages per input synchroniser (minimum 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable; tracking continues when low
clr  input  1  synchronous clear of Q and err
a_in  input  1  encoder phase A, asynchronous
b_in  input  1  encoder phase B, asynchronous
Q  output  N  position count
dir  output  1  last legal step direction: 1 = up, 0 = down
step  output  1  one-cycle pulse on every counted step
err  output  1  sticky flag for an illegal transition (both phases changed)
tc_up  output  1  level, high when Q == 2^N-1
tc_down  output  1  level, high when Q == 0

Behaviour:
- Reset (rst=1 at a clk edge): Q=0, dir=0, step=0, err=0, sync flops=0, prev=00, FSM to PRIME. Reset applied mid-sequence discards any in-flight state.
- Synchronisers: a_s and b_s are the outputs of SYNC_STAGES flops. Each input has its own chain.
- FSM states:
  - PRIME: stays for SYNC_STAGES cycles after reset, then loads prev<={a_s,b_s} with no count and no err, and moves to RUN.
  - RUN: compares cur={a_s,b_s} against prev every cycle, then sets prev<=cur.
- Up sequence ({A,B}): 00→10→11→01→00. Down sequence: 00→01→11→10→00.
- Legal step with en=1:
  - Q <= Q±1 modulo 2^N.
  - dir updates.
  - step=1 for exactly one cycle.
- Wrap-around: up at 2^N-1 gives 0; down at 0 gives 2^N-1. There is no saturation and no extra flag beyond tc_up/tc_down.
- cur==prev: no change, step=0.
- Illegal step (cur XOR prev == 11):
  - err <= 1 (sticky).
  - Q and dir are unchanged, step=0.
  - prev is still updated, so the decoder resynchronises.
- en=0: prev still tracks cur, and an illegal transition still sets err. Q, dir and step are held, with step=0. When en rises again there is no burst of catch-up counts.
- clr=1:
  - Q<=0 and err<=0.
  - clr beats a simultaneous step: Q=0, step=0 that cycle.
  - dir and prev are unaffected.
- rst has priority over clr, en and all other inputs.
- Latency: an input edge sampled at clk edge k appears on Q and step after edge k+SYNC_STAGES. With the default this is 3 clk edges from the sampling edge to the Q update.
- tc_up and tc_down are combinational from Q.
- Input rate: inputs must be stable for at least 2 clk periods per phase state. Faster inputs may alias to illegal transitions, which are flagged through err.

Decomposition:
- Shared package quad_pkg:
  - localparams for phase encodings (PH_00, PH_10, PH_11, PH_01)
  - FSM state encodings (ST_PRIME, ST_RUN)
  - DIR_UP=1 and DIR_DOWN=0
- Sub-module: sync_ff (parameter STAGES, width 1, synchronous reset to 0). It is instantiated twice, for A and B.
- The transition decode is a single combinational block inside quad_decoder.

Test Plan:
- Reset with a_in=b_in=1: after 3 cycles Q=0, err=0. No spurious count or err from the 00→11 power-up mismatch.
- Drive 4 full up cycles (16 edges, each held 4 clks) from Q=0: Q=16, dir=1, 16 step pulses. Then 5 down edges: Q=11, dir=0.
- Wrap: from Q=255, one up edge gives Q=0, tc_down=1, tc_up=0. One down edge then gives Q=255, tc_up=1.
- Illegal: jump 00→11 directly: err=1, Q unchanged, step=0. A following legal edge 11→01 counts up. Only clr clears err.
- en=0 while applying 6 up edges: Q held, step=0. Set en=1 with no further edges: Q still unchanged. The next up edge gives Q+1.
- clr asserted in the same cycle as a counted step: Q=0, step=0, err=0. Assert rst mid-rotation: all outputs 0 next edge, re-prime, then normal counting resumes.
